// File: rtl/mem_issue_queue.sv
// In-order issue queue for memory micro-ops: tracks source readiness via wakeup
// broadcasts and presents the oldest entry once both operands are ready.
module mem_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned WAKE_N    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [PREG_W-1:0]          dispatch_psrc0_i,
  input  logic [PREG_W-1:0]          dispatch_psrc1_i,
  input  logic                       dispatch_src0_ready_i,
  input  logic                       dispatch_src1_ready_i,
  input  logic [PAYLOAD_W-1:0]       dispatch_payload_i,
  input  logic [WAKE_N-1:0]          wakeup_valid_i,
  input  logic [WAKE_N*PREG_W-1:0]   wakeup_preg_i,
  output logic                       issue_valid_o,
  output logic [PREG_W-1:0]          issue_psrc0_o,
  output logic [PREG_W-1:0]          issue_psrc1_o,
  output logic [PAYLOAD_W-1:0]       issue_payload_o,
  input  logic                       exe_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [PtrW-1:0]      head_q, tail_q;
  logic                 valid_q   [DEPTH];
  logic                 rdy0_q    [DEPTH];
  logic                 rdy1_q    [DEPTH];
  logic [PREG_W-1:0]    psrc0_q   [DEPTH];
  logic [PREG_W-1:0]    psrc1_q   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic [IdxW-1:0] head_idx, tail_idx;
  logic            empty, full, enq, deq;
  logic            wake0 [DEPTH];
  logic            wake1 [DEPTH];
  logic            disp_wake0, disp_wake1;

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);
  assign count_o  = tail_q - head_q;

  assign dispatch_ready_o = ~full;
  assign enq = dispatch_valid_i & dispatch_ready_o;
  assign deq = issue_valid_o & exe_ready_i;

  // Tag match of every entry source (and the incoming op) against all broadcast ports.
  always_comb begin
    disp_wake0 = 1'b0;
    disp_wake1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wake0[i] = 1'b0;
      wake1[i] = 1'b0;
    end
    for (int k = 0; k < WAKE_N; k++) begin
      if (wakeup_valid_i[k]) begin
        if (wakeup_preg_i[k*PREG_W +: PREG_W] == dispatch_psrc0_i) disp_wake0 = 1'b1;
        if (wakeup_preg_i[k*PREG_W +: PREG_W] == dispatch_psrc1_i) disp_wake1 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (wakeup_preg_i[k*PREG_W +: PREG_W] == psrc0_q[i]) wake0[i] = 1'b1;
          if (wakeup_preg_i[k*PREG_W +: PREG_W] == psrc1_q[i]) wake1[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        rdy0_q[i]  <= 1'b0;
        rdy1_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && wake0[i]) rdy0_q[i] <= 1'b1;
        if (valid_q[i] && wake1[i]) rdy1_q[i] <= 1'b1;
      end
      if (deq) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PtrOne;
      end
      // No full-plus-dequeue bypass, so the tail slot never aliases the head being freed.
      if (enq) begin
        valid_q[tail_idx]   <= 1'b1;
        psrc0_q[tail_idx]   <= dispatch_psrc0_i;
        psrc1_q[tail_idx]   <= dispatch_psrc1_i;
        rdy0_q[tail_idx]    <= dispatch_src0_ready_i | disp_wake0;
        rdy1_q[tail_idx]    <= dispatch_src1_ready_i | disp_wake1;
        payload_q[tail_idx] <= dispatch_payload_i;
        tail_q              <= tail_q + PtrOne;
      end
    end
  end

  always_comb begin
    issue_valid_o   = ~empty & valid_q[head_idx] & rdy0_q[head_idx] & rdy1_q[head_idx];
    issue_psrc0_o   = '0;
    issue_psrc1_o   = '0;
    issue_payload_o = '0;
    if (issue_valid_o) begin
      issue_psrc0_o   = psrc0_q[head_idx];
      issue_psrc1_o   = psrc1_q[head_idx];
      issue_payload_o = payload_q[head_idx];
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of the in-order issue rules.
module tb_mem_issue_queue;

  localparam int DEPTH = 8;
  localparam int PW    = 6;
  localparam int DW    = 96;
  localparam int WN    = 4;

  logic          clk = 1'b0;
  logic          rst, flush, dv, s0r, s1r, exe_ready;
  logic [PW-1:0] psrc0, psrc1;
  logic [DW-1:0] payload;
  logic [WN-1:0] wv;
  logic [WN*PW-1:0] wp;
  logic          dispatch_ready, issue_valid;
  logic [PW-1:0] issue_psrc0, issue_psrc1;
  logic [DW-1:0] issue_payload;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    bit            r0;
    bit            r1;
    logic [DW-1:0] pl;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(DEPTH), .PREG_W(PW), .PAYLOAD_W(DW), .WAKE_N(WN)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_i               (flush),
    .dispatch_valid_i      (dv),
    .dispatch_ready_o      (dispatch_ready),
    .dispatch_psrc0_i      (psrc0),
    .dispatch_psrc1_i      (psrc1),
    .dispatch_src0_ready_i (s0r),
    .dispatch_src1_ready_i (s1r),
    .dispatch_payload_i    (payload),
    .wakeup_valid_i        (wv),
    .wakeup_preg_i         (wp),
    .issue_valid_o         (issue_valid),
    .issue_psrc0_o         (issue_psrc0),
    .issue_psrc1_o         (issue_psrc1),
    .issue_payload_o       (issue_payload),
    .exe_ready_i           (exe_ready),
    .count_o               (count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [PW-1:0] t);
    for (int k = 0; k < WN; k++)
      if (wv[k] && wp[k*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_iv();
    return q.size() > 0 && q[0].r0 && q[0].r1;
  endfunction

  task automatic compare_model();
    bit iv;
    iv = m_iv();
    chk("issue_valid", issue_valid, iv);
    chk("count", count, q.size());
    chk("dispatch_ready", dispatch_ready, q.size() < DEPTH);
    chk("issue_psrc0", issue_psrc0, iv ? q[0].p0 : '0);
    chk("issue_psrc1", issue_psrc1, iv ? q[0].p1 : '0);
    chk("issue_payload", issue_payload, iv ? q[0].pl : '0);
  endtask

  task automatic model_update();
    entry_t e;
    bit iv, can_enq;
    iv = m_iv();
    can_enq = q.size() < DEPTH;
    if (rst || flush) begin
      q.delete();
      return;
    end
    foreach (q[i]) begin
      if (hit(q[i].p0)) q[i].r0 = 1'b1;
      if (hit(q[i].p1)) q[i].r1 = 1'b1;
    end
    if (iv && exe_ready) void'(q.pop_front());
    if (dv && can_enq) begin
      e.p0 = psrc0; e.p1 = psrc1; e.pl = payload;
      e.r0 = s0r || hit(psrc0);
      e.r1 = s1r || hit(psrc1);
      q.push_back(e);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, then return just after the edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; dv = 0; s0r = 0; s1r = 0; exe_ready = 0;
    psrc0 = '0; psrc1 = '0; payload = '0; wv = '0; wp = '0;
  endtask

  task automatic disp(input logic [PW-1:0] a, input bit ar, input logic [PW-1:0] b,
                      input bit br, input logic [DW-1:0] pl);
    dv = 1; psrc0 = a; s0r = ar; psrc1 = b; s1r = br; payload = pl;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    chk("reset_count", count, 4'd0);
    chk("reset_dready", dispatch_ready, 1'b1);
    chk("reset_ivalid", issue_valid, 1'b0);

    // Ready-at-dispatch op issues one cycle later.
    exe_ready = 1;
    disp(6'd1, 1, 6'd2, 1, 96'hABC);
    step();
    dv = 0;
    chk("t1_ivalid", issue_valid, 1'b1);
    chk("t1_payload", issue_payload, 96'hABC);
    chk("t1_count1", count, 4'd1);
    step();
    chk("t1_count0", count, 4'd0);

    // Head blocked on tag 5 holds back a younger ready op.
    disp(6'd5, 0, 6'd3, 1, 96'hA1);
    step();
    disp(6'd7, 1, 6'd8, 1, 96'hB2);
    step();
    dv = 0;
    chk("t2_blocked", issue_valid, 1'b0);
    chk("t2_count", count, 4'd2);
    step();
    chk("t2_still_blocked", issue_valid, 1'b0);
    wv = 4'b0100;
    wp = 24'd5 << 12;
    step();
    wv = '0; wp = '0;
    chk("t2_a_valid", issue_valid, 1'b1);
    chk("t2_a_payload", issue_payload, 96'hA1);
    step();
    chk("t2_b_payload", issue_payload, 96'hB2);
    step();
    chk("t2_drained", count, 4'd0);

    // Same-cycle wakeup of an incoming op.
    exe_ready = 0;
    disp(6'd4, 1, 6'd9, 0, 96'hC3);
    wv = 4'b0001;
    wp = 24'd9;
    step();
    dv = 0; wv = '0; wp = '0;
    chk("t3_ivalid", issue_valid, 1'b1);
    chk("t3_psrc1", issue_psrc1, 6'd9);
    exe_ready = 1;
    step();

    // Fill to full, try one more, then drain in order.
    exe_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(6'(i), 1, 6'(i + 1), 1, 96'(i + 16));
      step();
    end
    chk("t4_count_full", count, 4'd8);
    chk("t4_dready_full", dispatch_ready, 1'b0);
    disp(6'd0, 1, 6'd0, 1, 96'hDEAD);
    step();
    dv = 0;
    chk("t4_refused", count, 4'd8);
    exe_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_order", issue_payload, 96'(i + 16));
      step();
      if (i == 0) chk("t4_dready_rise", dispatch_ready, 1'b1);
    end
    chk("t4_empty", count, 4'd0);

    // Sustained enqueue/dequeue pairs across pointer wrap.
    exe_ready = 0;
    for (int i = 0; i < 2; i++) begin
      disp(6'd1, 1, 6'd1, 1, 96'(i + 100));
      step();
    end
    exe_ready = 1;
    for (int i = 0; i < 20; i++) begin
      chk("t5_order", issue_payload, 96'(i + 100));
      disp(6'd1, 1, 6'd1, 1, 96'(i + 102));
      step();
      chk("t5_count", count, 4'd2);
    end
    dv = 0;
    step();
    step();
    chk("t5_drained", count, 4'd0);

    // Flush with a dispatch in the same cycle.
    exe_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(6'd2, 1, 6'd2, 1, 96'(i + 200));
      step();
    end
    chk("t6_count3", count, 4'd3);
    flush = 1;
    disp(6'd2, 1, 6'd2, 1, 96'h999);
    step();
    flush = 0; dv = 0;
    chk("t6_count0", count, 4'd0);
    chk("t6_ivalid", issue_valid, 1'b0);
    step();

    // Random traffic with occasional stall bursts, flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      dv        = ($urandom_range(0, 3) != 0);
      psrc0     = 6'($urandom_range(0, 15));
      psrc1     = 6'($urandom_range(0, 15));
      s0r       = ($urandom_range(0, 2) == 0);
      s1r       = ($urandom_range(0, 2) == 0);
      payload   = {$urandom, $urandom, $urandom};
      wv        = 4'($urandom);
      wp        = 24'({$urandom_range(0, 15), $urandom_range(0, 15)} & 32'h0);
      for (int k = 0; k < WN; k++) wp[k*PW +: PW] = 6'($urandom_range(0, 15));
      exe_ready = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
